// File: rtl/uart_rx_axis_buffered_pkg.sv
// Shared types and timing helpers for the buffered UART receiver.
// Bit-period math, parity-mode codes, FSM states and the FIFO word layout.
package uart_rx_axis_buffered_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rx_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Rounded clocks per bit; 64-bit math keeps large MHz values safe.
    function automatic int calc_clks_per_bit(input int clk_mhz, input int bit_rate);
        longint num;
        num = longint'(clk_mhz) * 64'd1000000 + longint'(bit_rate / 2);
        return int'(num / longint'(bit_rate));
    endfunction

    function automatic int calc_half_bit(input int clk_mhz, input int bit_rate);
        return calc_clks_per_bit(clk_mhz, bit_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received words.
// The head is visible on rdata whenever empty is low; rdata reads zero when empty.
module uart_rx_fifo
    import uart_rx_axis_buffered_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         push,
    input  rx_word_t                     wdata,
    input  logic                         pop,
    output rx_word_t                     rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    rx_word_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_axis_buffered.sv
// UART receiver feeding an AXI-Stream master through a FWFT FIFO.
// Errored words are delivered with tuser set; a full FIFO drops the word and pulses overflow.
module uart_rx_axis_buffered
    import uart_rx_axis_buffered_pkg::*;
#(
    parameter int CLK_FREQ      = 100,
    parameter int BIT_RATE      = 115200,
    parameter int BIT_PER_WORD  = 8,
    parameter int PARITY_BIT    = 0,
    parameter int STOP_BITS_NUM = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        RX,
    output logic [7:0]  out_tdata,
    output logic        out_tuser,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        overflow
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BIT_RATE);
    localparam int HALF_BIT     = calc_half_bit(CLK_FREQ, BIT_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int CW           = $clog2(FIFO_DEPTH + 1);
    localparam int SYNC_STAGES  = 2;

    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_DATA = 3'(BIT_PER_WORD - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS_NUM - 1);
    localparam logic             PAR_SENSE = (PARITY_BIT == PAR_ODD);

    logic                     rx_meta, rx_sync, rx_prev;
    logic [SYNC_STAGES:0]     vld_pipe;
    logic                     start_edge;

    rx_state_t                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               idx_q, idx_d;
    logic [BIT_PER_WORD-1:0]  data_q, data_d;
    logic                     err_q, err_d;
    logic                     tick;
    logic                     push;

    rx_word_t                 push_word, head;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]            fifo_count;

    // vld_pipe marks when rx_prev holds a real line sample, so a line that is
    // already low at reset release is not mistaken for a start edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            vld_pipe <= '0;
        end else begin
            rx_meta  <= RX;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign start_edge = vld_pipe[SYNC_STAGES] && rx_prev && !rx_sync;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        err_d   = err_q;
        push    = 1'b0;
        tick    = (cnt_q == BIT_END);
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_edge) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d  = '0;
                    data_d = {rx_sync, data_q[BIT_PER_WORD-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_BIT != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    err_d   = err_q | ((^data_q ^ rx_sync) != PAR_SENSE);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (!rx_sync) err_d = 1'b1;
                    // Leave at mid-stop so the next start edge is not missed.
                    if (idx_q == LAST_STOP) begin
                        push    = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign push_word = '{err: err_q | ~rx_sync, data: DATA_W'(data_q)};

    assign fifo_pop  = out_tready && (fifo_count != '0);
    assign fifo_push = push && (!fifo_full || fifo_pop);
    assign overflow  = push && fifo_full && !fifo_pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (fifo_push),
        .wdata   (push_word),
        .pop     (fifo_pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_tvalid = !fifo_empty;
    assign out_tdata  = head.data;
    assign out_tuser  = head.err;

endmodule
